// File: rtl/pc_gen.sv
// Program counter generator: boot/fetch sequencing, fetch handshake, hold, and redirects.
// Optional trap/mret support and the epc register are built when PC_GEN_TRAP_EN is defined.
module pc_gen #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter int unsigned       STEP        = 4,
  parameter int unsigned       HOLD_W      = 3,
  parameter int unsigned       HOLD_PC_LVL = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              jtag_reset_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              pc_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              redirect_o,
  output logic              misalign_o
`ifdef PC_GEN_TRAP_EN
  ,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic [ADDR_W-1:0] trap_epc_i,
  input  logic              mret_i,
  output logic [ADDR_W-1:0] epc_o
`endif
);

  localparam logic [ADDR_W-1:0] StepVal = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] LowMask = ADDR_W'(STEP - 1);
  localparam logic [HOLD_W-1:0] HoldLvl = HOLD_W'(HOLD_PC_LVL);

  typedef enum logic [0:0] {StBoot, StFetch} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              redirect_q;
  logic              misalign_q;
  logic              hold_pc;
  logic              fire;
  logic              redir_req;
  logic [ADDR_W-1:0] redir_tgt;

`ifdef PC_GEN_TRAP_EN
  logic [ADDR_W-1:0] epc_q;
  assign epc_o = epc_q;
`endif

  assign hold_pc    = (hold_flag_i >= HoldLvl);
  assign pc_valid_o = (state_q == StFetch) && !hold_pc;
  assign fire       = pc_valid_o && pc_ready_i;
  assign pc_o       = pc_q;
  assign redirect_o = redirect_q;
  assign misalign_o = misalign_q;

  // Redirect sources, lowest priority first so later assignments win.
  always_comb begin
    redir_req = jump_flag_i;
    redir_tgt = jump_addr_i;
`ifdef PC_GEN_TRAP_EN
    if (trap_flag_i) begin
      redir_req = 1'b1;
      redir_tgt = trap_vec_i;
    end else if (mret_i) begin
      redir_req = 1'b1;
      redir_tgt = epc_q;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StBoot;
      pc_q       <= RESET_ADDR;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
`ifdef PC_GEN_TRAP_EN
      epc_q      <= '0;
`endif
    end else if (jtag_reset_i) begin
      state_q    <= StBoot;
      pc_q       <= RESET_ADDR;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      // BOOT always lasts one cycle; any non-reset edge lands in FETCH.
      state_q <= StFetch;
      if (redir_req) begin
        pc_q       <= redir_tgt & ~LowMask;
        redirect_q <= 1'b1;
        misalign_q <= |(redir_tgt & LowMask);
      end else begin
        redirect_q <= 1'b0;
        misalign_q <= 1'b0;
        if (fire) begin
          pc_q <= pc_q + StepVal;
        end
      end
`ifdef PC_GEN_TRAP_EN
      if (trap_flag_i) begin
        epc_q <= trap_epc_i;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Randomized self-checking bench for pc_gen against a behavioural next-PC model.
// Builds with or without PC_GEN_TRAP_EN.
module tb_pc_gen;

  localparam int unsigned ADDR_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              jtag_reset_i = 1'b0;
  logic [2:0]        hold_flag_i = '0;
  logic              jump_flag_i = 1'b0;
  logic [ADDR_W-1:0] jump_addr_i = '0;
  logic              pc_ready_i = 1'b0;
  logic [ADDR_W-1:0] pc_o;
  logic              pc_valid_o;
  logic              redirect_o;
  logic              misalign_o;
`ifdef PC_GEN_TRAP_EN
  logic              trap_flag_i = 1'b0;
  logic [ADDR_W-1:0] trap_vec_i = '0;
  logic [ADDR_W-1:0] trap_epc_i = '0;
  logic              mret_i = 1'b0;
  logic [ADDR_W-1:0] epc_o;
  logic [ADDR_W-1:0] m_epc;
`endif

  pc_gen #(
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (32'h0),
    .STEP       (4),
    .HOLD_W     (3),
    .HOLD_PC_LVL(1)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .jtag_reset_i(jtag_reset_i),
    .hold_flag_i (hold_flag_i),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .pc_ready_i  (pc_ready_i),
    .pc_o        (pc_o),
    .pc_valid_o  (pc_valid_o),
    .redirect_o  (redirect_o),
    .misalign_o  (misalign_o)
`ifdef PC_GEN_TRAP_EN
    ,
    .trap_flag_i (trap_flag_i),
    .trap_vec_i  (trap_vec_i),
    .trap_epc_i  (trap_epc_i),
    .mret_i      (mret_i),
    .epc_o       (epc_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state
  logic [ADDR_W-1:0] m_pc;
  bit                m_boot, m_red, m_mis, m_known;

  task automatic chk(input string name, input logic [ADDR_W-1:0] act,
                     input logic [ADDR_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_valid();
    return !m_boot && (hold_flag_i < 3'd1);
  endfunction

  task automatic compare_model();
    if (m_known) begin
      chk("model_pc", pc_o, m_pc);
      chk("model_valid", 32'(pc_valid_o), 32'(model_valid()));
      chk("model_redirect", 32'(redirect_o), 32'(m_red));
      chk("model_misalign", 32'(misalign_o), 32'(m_mis));
`ifdef PC_GEN_TRAP_EN
      chk("model_epc", epc_o, m_epc);
`endif
    end
  endtask

  // What the registers must hold after this edge, from the priority rules.
  task automatic model_edge();
    bit                take;
    bit                v;
    logic [ADDR_W-1:0] tgt;
    v    = model_valid();
    take = 1'b0;
    tgt  = '0;
    if (rst_i || jtag_reset_i) begin
      m_pc   = 32'h0;
      m_boot = 1'b1;
      m_red  = 1'b0;
      m_mis  = 1'b0;
`ifdef PC_GEN_TRAP_EN
      if (rst_i) m_epc = '0;
`endif
      if (rst_i) m_known = 1'b1;
    end else begin
`ifdef PC_GEN_TRAP_EN
      if (trap_flag_i) begin
        take = 1'b1;
        tgt  = trap_vec_i;
      end else if (mret_i) begin
        take = 1'b1;
        tgt  = m_epc;
      end
      if (trap_flag_i) m_epc = trap_epc_i;
`endif
      if (!take && jump_flag_i) begin
        take = 1'b1;
        tgt  = jump_addr_i;
      end
      if (take) begin
        m_pc  = (tgt / 4) * 4;
        m_red = 1'b1;
        m_mis = (tgt % 4) != 0;
      end else begin
        m_red = 1'b0;
        m_mis = 1'b0;
        if (v && pc_ready_i) m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
  endtask

  // One cycle: check settled outputs, take the edge, update the model.
  task automatic tick();
    #1;
    compare_model();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  initial begin
    m_known = 1'b0;
    m_pc    = '0;
    m_boot  = 1'b1;
    m_red   = 1'b0;
    m_mis   = 1'b0;
`ifdef PC_GEN_TRAP_EN
    m_epc   = '0;
`endif
    pc_ready_i = 1'b1;
    tick();
    tick();
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_valid", 32'(pc_valid_o), 32'd0);
    chk("reset_redirect", 32'(redirect_o), 32'd0);
    chk("reset_misalign", 32'(misalign_o), 32'd0);

    // Sequential fetch after reset, then backpressure at 8
    rst_i = 1'b0;
    #1;
    chk("boot_valid", 32'(pc_valid_o), 32'd0);
    tick();
    chk("seq_pc0", pc_o, 32'h0);
    chk("seq_valid0", 32'(pc_valid_o), 32'd1);
    tick();
    chk("seq_pc4", pc_o, 32'h4);
    tick();
    chk("seq_pc8", pc_o, 32'h8);
    pc_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc", pc_o, 32'h8);
      chk("bp_valid", 32'(pc_valid_o), 32'd1);
    end
    pc_ready_i = 1'b1;
    tick();
    chk("bp_release_pc", pc_o, 32'hC);

    // Jump under hold with misaligned target
    hold_flag_i = 3'd1;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h103;
    tick();
    jump_flag_i = 1'b0;
    #1;
    chk("jh_pc", pc_o, 32'h100);
    chk("jh_redirect", 32'(redirect_o), 32'd1);
    chk("jh_misalign", 32'(misalign_o), 32'd1);
    chk("jh_valid", 32'(pc_valid_o), 32'd0);
    tick();
    chk("jh_redirect_end", 32'(redirect_o), 32'd0);
    chk("jh_misalign_end", 32'(misalign_o), 32'd0);
    chk("jh_pc_held", pc_o, 32'h100);
    hold_flag_i = 3'd0;
    #1;
    chk("jh_valid_rel", 32'(pc_valid_o), 32'd1);
    tick();
    chk("jh_next_pc", pc_o, 32'h104);

    // Wrap-around
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_flag_i = 1'b0;
    chk("wrap_pre_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pre_mis", 32'(misalign_o), 32'd0);
    tick();
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_redirect", 32'(redirect_o), 32'd0);

    // JTAG reset beats jump and handshake
    tick();
    jtag_reset_i = 1'b1;
    jump_flag_i  = 1'b1;
    jump_addr_i  = 32'h40;
    tick();
    jtag_reset_i = 1'b0;
    jump_flag_i  = 1'b0;
    #1;
    chk("prio_pc", pc_o, 32'h0);
    chk("prio_valid", 32'(pc_valid_o), 32'd0);
    chk("prio_redirect", 32'(redirect_o), 32'd0);
    tick();

`ifdef PC_GEN_TRAP_EN
    trap_flag_i = 1'b1;
    trap_vec_i  = 32'h80;
    trap_epc_i  = 32'h24;
    tick();
    trap_flag_i = 1'b0;
    chk("trap_pc", pc_o, 32'h80);
    chk("trap_epc", epc_o, 32'h24);
    chk("trap_redirect", 32'(redirect_o), 32'd1);
    tick();
    tick();
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk("mret_pc", pc_o, 32'h24);
    chk("mret_redirect", 32'(redirect_o), 32'd1);
    tick();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_i        = ($urandom_range(0, 99) == 0);
      jtag_reset_i = ($urandom_range(0, 79) == 0);
      hold_flag_i  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      jump_flag_i  = ($urandom_range(0, 7) == 0);
      jump_addr_i  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom);
      pc_ready_i   = ($urandom_range(0, 3) != 0);
`ifdef PC_GEN_TRAP_EN
      trap_flag_i  = ($urandom_range(0, 15) == 0);
      trap_vec_i   = 32'($urandom);
      trap_epc_i   = 32'($urandom);
      mret_i       = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: PC width in bits.
REQ-002 The block SHALL have parameter RESET_ADDR, default 0: PC value after reset or JTAG reset.
REQ-003 The block SHALL have parameter STEP, default 4: sequential increment, power of two, 2 or 4.
REQ-004 The block SHALL have parameter HOLD_W, default 3: hold-flag width.
REQ-005 The block SHALL have parameter HOLD_PC_LVL, default 1: minimum hold level that stalls the PC.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port jtag_reset_i, input, 1 bit: debug reset request.
REQ-009 The block SHALL have port hold_flag_i, input, HOLD_W bits: pipeline hold level.
REQ-010 The block SHALL have port jump_flag_i, input, 1 bit: jump/branch redirect request.
REQ-011 The block SHALL have port jump_addr_i, input, ADDR_W bits: jump target.
REQ-012 The block SHALL have port pc_ready_i, input, 1 bit: fetch unit accepts pc_o.
REQ-013 The block SHALL have port pc_o, output, ADDR_W bits: current fetch address.
REQ-014 The block SHALL have port pc_valid_o, output, 1 bit: pc_o is a valid fetch request.
REQ-015 The block SHALL have port redirect_o, output, 1 bit: one-cycle pulse, PC was redirected (flush).
REQ-016 The block SHALL have port misalign_o, output, 1 bit: one-cycle pulse, redirect target had nonzero bits below log2(STEP).

Function
REQ-017 The state machine SHALL have states BOOT and FETCH; the state after reset SHALL be BOOT.
REQ-018 BOOT SHALL last exactly one cycle with pc_valid_o=0, then go to FETCH.
REQ-019 In FETCH, pc_valid_o SHALL equal (hold_flag_i < HOLD_PC_LVL), combinationally.
REQ-020 Next-PC priority SHALL be: rst_i > jtag_reset_i > trap > mret > jump_flag_i > hold > handshake.
REQ-021 jtag_reset_i=1 SHALL load RESET_ADDR, enter BOOT and clear redirect_o and misalign_o, in any state.
REQ-022 A redirect (jump, trap or mret) SHALL load the target with bits below log2(STEP) forced to 0 on the next edge, in BOOT or FETCH.
REQ-023 A redirect SHALL pulse redirect_o=1 for exactly the following cycle, regardless of hold or pc_ready_i.
REQ-024 misalign_o SHALL pulse in the same cycle as redirect_o if the raw target had nonzero low bits; otherwise it SHALL stay 0.
REQ-025 When pc_valid_o=1 and pc_ready_i=1 with no redirect, pc_o SHALL advance by STEP, modulo 2^ADDR_W (wrap to 0, no flag).
REQ-026 When pc_valid_o=1 and pc_ready_i=0, pc_o SHALL stay stable until accepted or redirected.
REQ-027 When hold_flag_i >= HOLD_PC_LVL, pc_o SHALL be held unless a redirect or reset has priority.
REQ-028 Because a redirect overrides a hold, the redirected address SHALL be presented once the hold releases.
REQ-029 A redirect in the same cycle as a handshake SHALL discard the increment; the next pc_o is the redirect target.

Reset
REQ-030 On rst_i=1 at a clock edge: pc_o=RESET_ADDR, pc_valid_o=0, redirect_o=0, misalign_o=0, state=BOOT, and epc_o=0 when present.
REQ-031 A reset mid-handshake SHALL abandon the outstanding request; the first request after reset is RESET_ADDR.

Configuration
REQ-032 The macro PC_GEN_TRAP_EN SHALL, when defined, add these ports: trap_flag_i (in, 1), trap_vec_i (in, ADDR_W), trap_epc_i (in, ADDR_W), mret_i (in, 1), epc_o (out, ADDR_W).
REQ-033 With the macro defined, trap_flag_i=1 SHALL load pc_o=trap_vec_i and epc_o=trap_epc_i on the same edge.
REQ-034 With the macro defined, mret_i=1 without a trap SHALL load pc_o=epc_o.
REQ-035 With the macro defined, trap and mret SHALL count as redirects for redirect_o and misalign_o.
REQ-036 With the macro undefined, the trap ports, the epc register and the trap/mret priority levels SHALL be absent, with behaviour otherwise identical.

Verification
REQ-037 Reset then sequential fetch: rst_i 1->0, pc_ready_i=1 -> valid low for 1 cycle, then pc_o 0,4,8,C on consecutive cycles.
REQ-038 Backpressure: pc_o=8, pc_ready_i=0 for 3 cycles -> pc_o holds 8 with valid=1; ready=1 -> next pc_o=C.
REQ-039 Jump under hold: hold_flag_i=1 plus jump to 0x103 -> pc_o=0x100, redirect_o=1, misalign_o=1 for 1 cycle, valid=0 until the hold drops.
REQ-040 Wrap-around: pc_o=0xFFFFFFFC, handshake -> pc_o=0x0, no redirect_o.
REQ-041 Priority: jtag_reset_i, jump and handshake in the same cycle -> pc_o=RESET_ADDR, BOOT, redirect_o=0.
REQ-042 With PC_GEN_TRAP_EN: trap to vec 0x80 with epc 0x24, later mret -> pc_o=0x80, epc_o=0x24, then pc_o=0x24, redirect_o pulsing each time.
